// File: rtl/mem_pkg.sv
// Shared constants for the data-RAM access path:
// opcodes, sequencer state encoding and RW polarity.
package mem_pkg;

    localparam logic [3:0] OP_ADR = 4'b1100;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    localparam logic RW_READ = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // A request starts a transfer only when RW agrees with the opcode.
    function automatic logic req_valid(
        input logic [3:0] op,
        input logic       rw
    );
        return ((op == OP_LDR) && (rw == RW_READ)) ||
               ((op == OP_STR) && (rw != RW_READ));
    endfunction

endpackage

// File: rtl/ram_access_sequencer_wait_timer.sv
// Saturating 8-bit wait counter; flags the last
// permitted WAIT cycle before an access is aborted.
module wait_timer
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    // Count WAIT cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    // True in the TIMEOUT-th WAIT cycle (count runs from zero).
    assign o_expired = (r_count >= LP_LAST);

endmodule

// File: rtl/ram_access_sequencer.sv
// Load/store sequencer between memory-control and data RAM:
// handshake, timeout, misalignment check and read-data hold.
module ram_access_sequencer
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic [3:0]        op_code,
    input  logic              RW,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] RAM_in,
    output logic [DATA_W-1:0] RAM_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    seq_state_t r_state;
    logic       r_rw;

    logic w_accept;
    logic w_misaligned;
    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_expired;

    assign w_accept     = req && req_valid(op_code, RW);
    assign w_misaligned = (address_in[1:0] != 2'b00);
    assign w_tmr_clr    = (r_state == SETUP);
    assign w_tmr_en     = (r_state == WAIT);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (Clk),
        .i_rst_n   (Reset),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    // Sequencer FSM with request latch, bus drive and read-data hold.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_rw      <= 1'b0;
            RAM_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (w_accept) begin
                        busy <= 1'b1;
                        r_rw <= RW;
                        if (w_misaligned) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            r_state   <= SETUP;
                            mem_en    <= 1'b1;
                            mem_we    <= ~RW;
                            mem_addr  <= address_in[ADDR_W-1:2];
                            mem_wdata <= RAM_in;
                        end
                    end
                end
                SETUP: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (mem_ready) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        mem_en  <= 1'b0;
                        if (r_rw == RW_READ) begin
                            RAM_out <= mem_rdata;
                        end
                    end else if (w_expired) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        mem_en  <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
